// File: rtl/instruction_queue_pkg.sv
// Shared types for the instruction queue: entry layout, instruction type codes and drain states.
package instruction_queue_pkg;

    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned PAYLOAD_W = 9;

    localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'b00;
    localparam logic [1:0] INSTR_TYPE_RAM        = 2'b01;
    localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'b10;
    localparam logic [1:0] INSTR_TYPE_LOOP       = 2'b11;

    typedef struct packed {
        logic [1:0]           instr_type;
        logic [PAYLOAD_W-1:0] payload;
        logic [ADDR_W-1:0]    cache_addr;
        logic [ADDR_W-1:0]    main_mem_addr;
        logic [ADDR_W-1:0]    d_cache_addr;
        logic [ADDR_W-1:0]    d_main_mem_addr;
    } instr_queue_entry_t;

    localparam int unsigned ENTRY_W = $bits(instr_queue_entry_t);

    typedef enum logic [1:0] {
        DQ_IDLE,
        DQ_RUN,
        DQ_DRAIN,
        DQ_DONE
    } drain_state_e;

endpackage

// File: rtl/instruction_queue_if.sv
// Push side from control_unit and dispatch side of the instruction queue, bundled as one interface.
interface instruction_queue_if
    import instruction_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 16
);

    logic                       queue_we;
    logic [1:0]                 queue_instr_type;
    logic [8:0]                 queue_arith_instr;
    logic [2:0]                 queue_ram_instr;
    logic [6:0]                 queue_ld_st_instr;
    logic [ADDR_W-1:0]          cache_addr;
    logic [ADDR_W-1:0]          main_mem_addr;
    logic [ADDR_W-1:0]          d_cache_addr;
    logic [ADDR_W-1:0]          d_main_mem_addr;
    logic                       program_complete;
    logic                       queue_stall;
    logic                       out_valid;
    logic                       out_ready;
    instr_queue_entry_t         out_entry;
    logic [$clog2(DEPTH):0]     occupancy;
    logic                       program_drained;
    logic                       overflow_error;

    modport master (
        output queue_we, queue_instr_type, queue_arith_instr, queue_ram_instr, queue_ld_st_instr,
        output cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr,
        output program_complete, out_ready,
        input  queue_stall, out_valid, out_entry, occupancy, program_drained, overflow_error
    );

    modport slave (
        input  queue_we, queue_instr_type, queue_arith_instr, queue_ram_instr, queue_ld_st_instr,
        input  cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr,
        input  program_complete, out_ready,
        output queue_stall, out_valid, out_entry, occupancy, program_drained, overflow_error
    );

endinterface

// File: rtl/instr_queue_pack.sv
// Packs the per-type control_unit payload fields and resolved addresses into one queue entry.
module instr_queue_pack
    import instruction_queue_pkg::*;
(
    input  logic [1:0]         instr_type,
    input  logic [8:0]         arith_instr,
    input  logic [2:0]         ram_instr,
    input  logic [6:0]         ld_st_instr,
    input  logic [ADDR_W-1:0]  cache_addr,
    input  logic [ADDR_W-1:0]  main_mem_addr,
    input  logic [ADDR_W-1:0]  d_cache_addr,
    input  logic [ADDR_W-1:0]  d_main_mem_addr,
    output instr_queue_entry_t entry
);

    always_comb begin
        entry                 = '0;
        entry.instr_type      = instr_type;
        entry.cache_addr      = cache_addr;
        entry.main_mem_addr   = main_mem_addr;
        entry.d_cache_addr    = d_cache_addr;
        entry.d_main_mem_addr = d_main_mem_addr;
        unique case (instr_type)
            INSTR_TYPE_ARITHMETIC: entry.payload = arith_instr;
            INSTR_TYPE_RAM:        entry.payload = {6'b0, ram_instr};
            INSTR_TYPE_LOAD_STORE: entry.payload = {2'b0, ld_st_instr};
            // LOOP is resolved inside control_unit and never reaches the queue.
            default:               entry.payload = '0;
        endcase
    end

endmodule

// File: rtl/instruction_queue.sv
// Decoupling FIFO between control_unit and dispatch: registered head, early stall,
// sticky overflow and a drain tracker that pulses once a finished program has emptied.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int unsigned DEPTH             = 16,
    parameter int unsigned ALMOST_FULL_SLACK = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    instruction_queue_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] SLACK_C = CNT_W'(ALMOST_FULL_SLACK);

    instr_queue_entry_t mem_q [DEPTH];
    instr_queue_entry_t new_entry;
    instr_queue_entry_t out_entry_q, out_entry_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             stall_q, stall_d;
    logic             overflow_q, overflow_d;
    logic             complete_prev_q;
    logic             out_valid;
    logic             push, pop, push_acc;
    drain_state_e     state_q, state_d;

    instr_queue_pack u_pack (
        .instr_type      (bus.queue_instr_type),
        .arith_instr     (bus.queue_arith_instr),
        .ram_instr       (bus.queue_ram_instr),
        .ld_st_instr     (bus.queue_ld_st_instr),
        .cache_addr      (bus.cache_addr),
        .main_mem_addr   (bus.main_mem_addr),
        .d_cache_addr    (bus.d_cache_addr),
        .d_main_mem_addr (bus.d_main_mem_addr),
        .entry           (new_entry)
    );

    assign out_valid = (count_q != '0);
    assign push      = bus.queue_we;
    assign pop       = out_valid && bus.out_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_acc  = push && ((count_q < DEPTH_C) || pop);

    always_comb begin
        wr_ptr_d   = push_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push_acc) - CNT_W'(pop);
        stall_d    = (DEPTH_C - count_d) <= SLACK_C;
        overflow_d = overflow_q || (push && !push_acc);
        // The incoming entry lands in the next head slot when the queue is empty or one-deep.
        if (push_acc && (wr_ptr_q == rd_ptr_d)) begin
            out_entry_d = new_entry;
        end else begin
            out_entry_d = mem_q[rd_ptr_d];
        end
        if (count_d == '0) begin
            out_entry_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DQ_IDLE: begin
                if (push_acc) begin
                    state_d = DQ_RUN;
                end else if (bus.program_complete && !complete_prev_q && (count_q == '0)) begin
                    state_d = DQ_DONE;
                end
            end
            DQ_RUN:   if (bus.program_complete) state_d = DQ_DRAIN;
            DQ_DRAIN: if ((count_q == '0) && !push) state_d = DQ_DONE;
            DQ_DONE:  state_d = DQ_IDLE;
            default:  state_d = DQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            stall_q         <= 1'b0;
            overflow_q      <= 1'b0;
            out_entry_q     <= '0;
            complete_prev_q <= 1'b0;
            state_q         <= DQ_IDLE;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            stall_q         <= stall_d;
            overflow_q      <= overflow_d;
            out_entry_q     <= out_entry_d;
            complete_prev_q <= bus.program_complete;
            state_q         <= state_d;
        end
    end

    assign bus.out_valid       = out_valid;
    assign bus.out_entry       = out_entry_q;
    assign bus.occupancy       = count_q;
    assign bus.queue_stall     = stall_q;
    assign bus.overflow_error  = overflow_q;
    assign bus.program_drained = (state_q == DQ_DONE);

endmodule
